// File: rtl/stimulus_pkg.sv
// stimulus_pkg: shared constants for the stimulus generator slice.
//   MODE_*  : word-sequence generators selectable through the MODE parameter.
//   St*     : FSM state encoding used by stimulus_gen.
package stimulus_pkg;

  // Sequence modes
  localparam int unsigned MODE_CONST = 0;
  localparam int unsigned MODE_RAMP  = 1;
  localparam int unsigned MODE_LFSR  = 2;

  // FSM state encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

endpackage

// File: rtl/stimulus_next_value.sv
// stimulus_next_value: combinational successor of the current stimulus word.
// Ports:
//   value      in  WIDTH  current word
//   next_value out WIDTH  word that follows value in the selected MODE
// CONST returns START, RAMP adds STEP modulo 2^WIDTH, LFSR shifts left and
// feeds back the parity of the tapped bits.
module stimulus_next_value
  import stimulus_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      MODE  = MODE_CONST,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] START = WIDTH'(10)
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value
);

  always_comb begin
    next_value = START;
    case (MODE)
      MODE_RAMP: next_value = value + STEP;
      MODE_LFSR: next_value = {value[WIDTH-2:0], ^(value & TAPS)};
      default:   next_value = START;
    endcase
  end

endmodule

// File: rtl/stimulus_gen.sv
// stimulus_gen: programmable stb/ack word source (constant, ramp or LFSR).
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-low reset
//   enable          in   run request, level-sensitive
//   output_out      out  WIDTH  current word, stable while stb is high
//   output_out_stb  out  word valid
//   output_out_ack  in   sink accepts the word (transfer on stb & ack)
//   done            out  one-shot sequence finished (sticky until reset)
// All outputs come straight from flops; ack and enable only steer next state.
module stimulus_gen
  import stimulus_pkg::*;
#(
  parameter int unsigned      WIDTH  = 16,
  parameter int unsigned      COUNT  = 1,
  parameter logic [WIDTH-1:0] START  = WIDTH'(10),
  parameter logic [WIDTH-1:0] STEP   = WIDTH'(1),
  parameter int unsigned      MODE   = MODE_CONST,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(16'hB400),
  parameter int unsigned      GAP    = 0,
  parameter int unsigned      REPEAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] output_out,
  output logic             output_out_stb,
  input  logic             output_out_ack,
  output logic             done
);

  // Parameter sanity
  if (WIDTH < 2) begin : g_bad_width
    $error("stimulus_gen: WIDTH must be at least 2");
  end
  if (COUNT < 1) begin : g_bad_count
    $error("stimulus_gen: COUNT must be at least 1");
  end
  if (MODE > MODE_LFSR) begin : g_bad_mode
    $error("stimulus_gen: unknown MODE");
  end
  if (REPEAT > 1) begin : g_bad_repeat
    $error("stimulus_gen: REPEAT must be 0 or 1");
  end

  localparam int unsigned IdxW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(COUNT - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic             stb_q, stb_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [GapW-1:0]  gap_q, gap_d;

  logic [WIDTH-1:0] next_value;
  logic             xfer;
  logic             last_word;

  stimulus_next_value #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .STEP  (STEP),
    .TAPS  (TAPS),
    .START (START)
  ) u_next_value (
    .value      (value_q),
    .next_value (next_value)
  );

  assign xfer      = stb_q & output_out_ack;
  assign last_word = (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    done_d  = done_q;
    value_d = value_q;
    idx_d   = idx_q;
    gap_d   = gap_q;

    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StSend;
          stb_d   = 1'b1;
        end
      end

      StSend: begin
        if (xfer) begin
          if (last_word && (REPEAT == 0)) begin
            state_d = StDone;
            stb_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (last_word) begin
              idx_d   = '0;
              value_d = START;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              value_d = next_value;
            end
            // enable is only honoured here, at a word boundary; a raised stb
            // is never withdrawn before its transfer.
            if (!enable) begin
              state_d = StIdle;
              stb_d   = 1'b0;
            end else if (GAP != 0) begin
              state_d = StGap;
              stb_d   = 1'b0;
              gap_d   = GapLoad;
            end
          end
        end
      end

      StGap: begin
        if (gap_q == '0) begin
          state_d = StSend;
          stb_d   = 1'b1;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end

      StDone: begin
        stb_d  = 1'b0;
        done_d = 1'b1;
      end

      default: begin
        state_d = StIdle;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      value_q <= START;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      value_q <= value_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  assign output_out     = value_q;
  assign output_out_stb = stb_q;
  assign done           = done_q;

endmodule

// File: tb/tb_stimulus_gen.sv
// Bench for stimulus_gen: six differently configured instances run side by side
// against a behavioural model (word k of a pass computed directly from the
// mode rules, stb/done predicted from transfer/gap/enable bookkeeping).
module tb_stimulus_gen;

  localparam int NI = 6;
  localparam int LG = 16;

  // 0: defaults  1: ramp wrap  2: LFSR seed 1  3: LFSR seed 8000
  // 4: ramp with gap, random ack  5: looping ramp with pause
  localparam int unsigned C_COUNT  [NI] = '{1, 4, 5, 2, 6, 3};
  localparam int unsigned C_START  [NI] = '{10, 'hFFFE, 1, 'h8000, 100, 5};
  localparam int unsigned C_STEP   [NI] = '{1, 1, 1, 1, 3, 1};
  localparam int unsigned C_MODE   [NI] = '{0, 1, 2, 2, 1, 1};
  localparam int unsigned C_GAP    [NI] = '{0, 0, 0, 0, 2, 0};
  localparam int unsigned C_REPEAT [NI] = '{0, 0, 0, 0, 0, 1};

  localparam logic [15:0] E1 [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  localparam logic [15:0] E2 [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
  localparam logic [15:0] E4 [6] = '{16'h0064, 16'h0067, 16'h006A, 16'h006D, 16'h0070,
                                     16'h0073};
  localparam logic [15:0] E5 [6] = '{16'd5, 16'd6, 16'd7, 16'd5, 16'd6, 16'd7};

  logic          clk;
  logic          rst;
  logic [NI-1:0] en, ack, stb, done;
  logic [15:0]   out [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    stimulus_gen #(
      .WIDTH  (16),
      .COUNT  (C_COUNT[g]),
      .START  (16'(C_START[g])),
      .STEP   (16'(C_STEP[g])),
      .MODE   (C_MODE[g]),
      .TAPS   (16'hB400),
      .GAP    (C_GAP[g]),
      .REPEAT (C_REPEAT[g])
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (en[g]),
      .output_out     (out[g]),
      .output_out_stb (stb[g]),
      .output_out_ack (ack[g]),
      .done           (done[g])
    );
  end

  // Word k of a pass, straight from the mode definitions.
  function automatic logic [15:0] word_at(input int i, input int k);
    logic [15:0] v;
    v = 16'(C_START[i]);
    if (C_MODE[i] == 1) begin
      v = 16'(C_START[i] + 32'(k) * C_STEP[i]);
    end else if (C_MODE[i] == 2) begin
      for (int n = 0; n < k; n++) v = {v[14:0], ^(v & 16'hB400)};
    end
    return v;
  endfunction

  // Behavioural model: index within pass, stb/done expectations, gap countdown.
  int m_idx [NI];
  int m_gap [NI];
  bit m_stb [NI];
  bit m_done [NI];
  int mi, mg;
  bit ms, md;

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_idx[i] = 0; m_gap[i] = 0; m_stb[i] = 0; m_done[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      mi = m_idx[i]; mg = m_gap[i]; ms = m_stb[i]; md = m_done[i];
      if (!rst) begin
        mi = 0; mg = 0; ms = 0; md = 0;
      end else if (!md) begin
        if (ms) begin
          if (ack[i]) begin
            if (mi == int'(C_COUNT[i]) - 1 && C_REPEAT[i] == 0) begin
              md = 1; ms = 0;
            end else begin
              mi = (mi + 1) % int'(C_COUNT[i]);
              if (!en[i]) ms = 0;
              else if (C_GAP[i] > 0) begin
                mg = int'(C_GAP[i]); ms = 0;
              end
            end
          end
        end else if (mg > 0) begin
          mg = mg - 1;
          if (mg == 0) ms = 1;
        end else if (en[i]) begin
          ms = 1;
        end
      end
      m_idx[i] <= mi; m_gap[i] <= mg; m_stb[i] <= ms; m_done[i] <= md;
    end
  end

  // Compare process
  int          n_cmp, n_fail, cyc, pin;
  bit          checking;
  logic [15:0] lg [NI][LG];
  int          lg_cyc [NI][LG];
  int          lg_n [NI];
  int          done_cyc [NI];
  int          low_run [NI];

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s inst%0d: got %0h, expected %0h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) begin
      lg_n[i] = 0; done_cyc[i] = -1; low_run[i] = 0;
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    clear_logs();
  end

  always @(negedge clk) begin
    if (checking) begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        chk("stb", i, 32'(stb[i]), 32'(m_stb[i]));
        chk("done", i, 32'(done[i]), 32'(m_done[i]));
        if (!m_done[i]) chk("word", i, 32'(out[i]), 32'(word_at(i, m_idx[i])));
        if (done[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
        if (stb[i] && ack[i]) begin
          if (i == 4 && lg_n[4] > 0) chk("gap_low_cycles", 4, 32'(low_run[4] >= 2), 32'd1);
          if (lg_n[i] < LG) begin
            lg[i][lg_n[i]] = out[i];
            lg_cyc[i][lg_n[i]] = cyc;
          end
          lg_n[i]++;
          low_run[i] = 0;
        end else if (!stb[i]) begin
          low_run[i]++;
        end
      end

      case (pin)
        1, 3: begin
          for (int i = 0; i < NI; i++) begin
            chk("rst_stb", i, 32'(stb[i]), 32'd0);
            chk("rst_done", i, 32'(done[i]), 32'd0);
            chk("rst_word", i, 32'(out[i]), 32'(16'(C_START[i])));
          end
          if (pin == 1) begin
            chk("model_ramp_wrap", 1, 32'(word_at(1, 2)), 32'h0000);
            chk("model_lfsr", 2, 32'(word_at(2, 4)), 32'h0010);
            chk("model_lfsr_fb", 3, 32'(word_at(3, 1)), 32'h0001);
          end
          clear_logs();
        end
        2: begin
          chk("const_count", 0, 32'(lg_n[0]), 32'd1);
          chk("const_word", 0, 32'(lg[0][0]), 32'd10);
          chk("ramp_count", 1, 32'(lg_n[1]), 32'd4);
          for (int k = 0; k < 4; k++) chk("ramp_word", 1, 32'(lg[1][k]), 32'(E1[k]));
          for (int k = 0; k < 3; k++)
            chk("ramp_b2b", 1, 32'(lg_cyc[1][k + 1] - lg_cyc[1][k]), 32'd1);
          chk("ramp_done_edge", 1, 32'(done_cyc[1]), 32'(lg_cyc[1][3] + 1));
          chk("lfsr_count", 2, 32'(lg_n[2]), 32'd5);
          for (int k = 0; k < 5; k++) chk("lfsr_word", 2, 32'(lg[2][k]), 32'(E2[k]));
          chk("lfsr_seed", 3, 32'(lg[3][0]), 32'h8000);
          chk("lfsr_fb", 3, 32'(lg[3][1]), 32'h0001);
          chk("gap_count", 4, 32'(lg_n[4]), 32'd6);
          for (int k = 0; k < 6; k++) chk("gap_word", 4, 32'(lg[4][k]), 32'(E4[k]));
          chk("loop_enough", 5, 32'(lg_n[5] >= 6), 32'd1);
          for (int k = 0; k < 6; k++) chk("loop_word", 5, 32'(lg[5][k]), 32'(E5[k]));
          chk("loop_no_done", 5, 32'(done_cyc[5]), 32'hFFFF_FFFF);
        end
        4: begin
          chk("restart_count", 0, 32'(lg_n[0]), 32'd1);
          chk("restart_word", 0, 32'(lg[0][0]), 32'd10);
          chk("restart_word", 1, 32'(lg[1][0]), 32'hFFFE);
          for (int k = 0; k < 3; k++) chk("restart_loop", 5, 32'(lg[5][k]), 32'(E5[k]));
        end
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    ack[4] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b0; en = '0; ack = '1; pin = 0; checking = 0;
    step();
    checking = 1;
    step();
    step();
    pin = 1;
    step();
    pin = 0;
    rst = 1'b1;
    en  = '1;
    for (int t = 0; t < 90; t++) begin
      if (t == 12) en[5] = 1'b0;
      if (t == 18) en[5] = 1'b1;
      step();
    end
    pin = 2;
    step();
    pin = 0;
    rst = 1'b0;       // reset while instance 5 is mid-stream with stb high
    step();
    pin = 3;
    rst = 1'b1;
    step();
    pin = 0;
    repeat (20) step();
    pin = 4;
    step();
    pin = 0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
